// File: rtl/slt_extend_unit.sv
// rtl/slt_extend_unit.sv - multi-cycle set-less-than, one CHUNK slice per cycle, MSB slice first
// Optional macro SLT_SIGNED_EN honours sign_mode; without it every comparison is unsigned.
module slt_extend_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sign_mode,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CHUNK-1:0] TOP_MASK = CHUNK'(1) << (CHUNK - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_CMP, ST_DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_sign;
   logic [IDXW-1:0]  r_idx;
   logic             r_decided;
   logic             r_lt;
   logic             r_result_lt;

   logic             w_sign_en;
   logic             w_flip;
   logic             w_last;
   logic [CHUNK-1:0] w_sa;
   logic [CHUNK-1:0] w_sb;
   logic             w_slice_lt;
   logic             w_slice_ne;
   logic             w_lt_final;

`ifdef SLT_SIGNED_EN
   assign w_sign_en = r_sign;
`else
   // sign_mode is still captured but forced off, so only unsigned ordering exists
   assign w_sign_en = r_sign & 1'b0;
`endif

   // Operands shift left each CMP cycle, so the current slice is always the top CHUNK bits.
   // Signed ordering flips only the sign bit, which lives in the first (MSB) slice.
   assign w_flip     = w_sign_en && (r_idx == '0);
   assign w_sa       = r_a[WIDTH-1 -: CHUNK] ^ (w_flip ? TOP_MASK : '0);
   assign w_sb       = r_b[WIDTH-1 -: CHUNK] ^ (w_flip ? TOP_MASK : '0);
   assign w_slice_lt = (w_sa < w_sb);
   assign w_slice_ne = (w_sa != w_sb);
   assign w_last     = (r_idx == IDXW'(NCHUNK - 1));
   assign w_lt_final = r_decided ? r_lt : w_slice_lt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_a         <= '0;
         r_b         <= '0;
         r_sign      <= 1'b0;
         r_idx       <= '0;
         r_decided   <= 1'b0;
         r_lt        <= 1'b0;
         r_result_lt <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_a       <= a;
                  r_b       <= b;
                  r_sign    <= sign_mode;
                  r_idx     <= '0;
                  r_decided <= 1'b0;
                  r_lt      <= 1'b0;
               end
            end
            ST_CMP: begin
               r_a   <= r_a << CHUNK;
               r_b   <= r_b << CHUNK;
               r_idx <= r_idx + IDXW'(1);
               if (!r_decided && w_slice_ne) begin
                  r_decided <= 1'b1;
                  r_lt      <= w_slice_lt;
               end
               if (w_last) begin
                  r_result_lt <= w_lt_final;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_CMP;
         end
         ST_CMP: begin
            busy = 1'b1;
            if (w_last) w_next = ST_DONE;
         end
         ST_DONE: begin
            busy   = 1'b1;
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      result    = '0;
      result[0] = r_result_lt;
   end

endmodule

// File: tb/tb_slt_extend_unit.sv
// tb/tb_slt_extend_unit.sv - directed-vector self-checking bench for slt_extend_unit
module tb_slt_extend_unit;

`ifdef SLT_SIGNED_EN
   localparam bit SGN = 1'b1;
`else
   localparam bit SGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic        sign_mode;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   slt_extend_unit #(.WIDTH(32), .CHUNK(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .a         (a),
      .b         (b),
      .sign_mode (sign_mode),
      .busy      (busy),
      .done      (done),
      .result    (result)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic tsm, input logic [31:0] exp_res);
      int          lat;
      int          bcyc;
      int          dcnt;
      logic [31:0] res;
      @(negedge clk);
      a = ta; b = tb_v; sign_mode = tsm; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a = $urandom; b = $urandom; sign_mode = ~tsm;
      lat = -1; bcyc = 0; dcnt = 0; res = '0;
      for (int k = 0; k < 10; k++) begin
         if (busy) bcyc++;
         if (done) begin
            dcnt++;
            if (lat < 0) lat = k;
            res = result;
         end
         @(posedge clk); #1;
      end
      check({tag, ".result"}, res, exp_res);
      check({tag, ".latency"}, 32'(lat), 32'd4);
      check({tag, ".busy_cycles"}, 32'(bcyc), 32'd5);
      check({tag, ".done_pulses"}, 32'(dcnt), 32'd1);
      check({tag, ".hold"}, result, exp_res);
   endtask

   initial begin
      int bcyc;
      int dcnt;
      logic [31:0] res;
      reset = 1'b1; start = 1'b0; a = '0; b = '0; sign_mode = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.result", result, 32'd0);

      // reset wins over a simultaneous start
      @(negedge clk);
      start = 1'b1; a = 32'd1; b = 32'd2;
      @(posedge clk); #1;
      check("rst_prio.busy", 32'(busy), 32'd0);
      start = 1'b0;
      reset = 1'b0;

      run_op("u_5_9",      32'd5,          32'd9,          1'b0, 32'd1);
      run_op("u_ff_0",     32'hFFFFFFFF,   32'h00000000,   1'b0, 32'd0);
      run_op("s_ff_0",     32'hFFFFFFFF,   32'h00000000,   1'b1, SGN ? 32'd1 : 32'd0);
      run_op("eq",         32'h12345678,   32'h12345678,   1'b0, 32'd0);
      run_op("s_eq",       32'h12345678,   32'h12345678,   1'b1, 32'd0);
      run_op("ff_100",     32'h000000FF,   32'h00000100,   1'b0, 32'd1);
      run_op("s_min_1",    32'h80000000,   32'h00000001,   1'b1, SGN ? 32'd1 : 32'd0);
      run_op("s_pos_neg",  32'h7F000000,   32'h80000000,   1'b1, SGN ? 32'd0 : 32'd1);
      run_op("s_lowslice", 32'h00000080,   32'h00000001,   1'b1, 32'd0);
      run_op("keep_lt",    32'h01FF0000,   32'h02000000,   1'b0, 32'd1);
      run_op("keep_ge",    32'h02000000,   32'h01FFFFFF,   1'b0, 32'd0);

      // start raised during CMP and held through DONE must be ignored
      @(negedge clk);
      a = 32'd9; b = 32'd5; sign_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bcyc = 0; dcnt = 0; res = 32'hDEAD;
      for (int k = 0; k < 10; k++) begin
         if (busy) bcyc++;
         if (done) begin dcnt++; res = result; end
         if (k == 1) begin start = 1'b1; a = 32'd1; b = 32'd2; end
         if (k == 5) start = 1'b0;
         @(posedge clk); #1;
      end
      check("midstart.result", res, 32'd0);
      check("midstart.done_pulses", 32'(dcnt), 32'd1);
      check("midstart.busy_cycles", 32'(bcyc), 32'd5);

      run_op("pre_abort", 32'h000000FF, 32'h00000100, 1'b0, 32'd1);

      // reset during the second CMP cycle aborts with no done pulse
      @(negedge clk);
      a = 32'd5; b = 32'd9; sign_mode = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort.busy", 32'(busy), 32'd0);
      check("abort.done", 32'(done), 32'd0);
      check("abort.result", result, 32'd0);
      reset = 1'b0;
      dcnt = 0;
      for (int k = 0; k < 6; k++) begin
         if (done) dcnt++;
         @(posedge clk); #1;
      end
      check("abort.no_done", 32'(dcnt), 32'd0);
      run_op("post_abort", 32'd1, 32'd2, 1'b0, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
